// File: rtl/if_stage_param.sv
// if_stage_param: fetch stage (PC, programmable IMEM, IF/ID register); `IF_BOUNDS_CHECK_EN adds sticky out-of-range faults
module if_stage_param #(
  parameter int XLEN = 32,
  parameter int IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PROGB,
  input  logic [XLEN-1:0] PROG_ADDR,
  input  logic [XLEN-1:0] PROG_INST,
  input  logic            PC_CTRL,
  input  logic [XLEN-1:0] PC_BRANCH_IN,
  input  logic            STALL,
  output logic [XLEN-1:0] IF_ID_PC_OUT,
  output logic [XLEN-1:0] IF_ID_INST_OUT,
  output logic            IF_ID_VALID,
  output logic            IF_FAULT
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h13);
  logic [XLEN-1:0] mem [IMEM_DEPTH];
  logic [XLEN-1:0] pc_q, pc_d, id_pc_q, id_pc_d, id_inst_q, id_inst_d;
  logic id_valid_q, id_valid_d, fault_q, fault_d;
  logic fetch_ok;
  logic unused_bits;
  assign unused_bits = ^{PROG_ADDR[XLEN-1:AW+2], PC_BRANCH_IN[1:0]};
`ifdef IF_BOUNDS_CHECK_EN
  assign fetch_ok = !fault_q && (pc_q >> (AW + 2)) == '0;
`else
  assign fetch_ok = 1'b1;
`endif
  always_ff @(posedge CLK)
    if (!RST && !PROGB && PROG_ADDR[1:0] == 2'b00) mem[PROG_ADDR[AW+1:2]] <= PROG_INST;
  always_comb begin
    pc_d = pc_q;
    id_pc_d = id_pc_q;
    id_inst_d = id_inst_q;
    id_valid_d = id_valid_q;
    fault_d = fault_q;
    if (!PROGB) begin
      pc_d = RESET_PC;
      id_pc_d = '0;
      id_inst_d = NOP;
      id_valid_d = 1'b0;
    end else if (PC_CTRL) begin
      pc_d = {PC_BRANCH_IN[XLEN-1:2], 2'b00};
      id_pc_d = '0;
      id_inst_d = NOP;
      id_valid_d = 1'b0;
`ifdef IF_BOUNDS_CHECK_EN
      fault_d = fault_q | (|PC_BRANCH_IN[1:0]);
`endif
    end else if (!STALL) begin
      pc_d = fetch_ok ? pc_q + XLEN'(4) : pc_q;
      id_pc_d = fetch_ok ? pc_q : '0;
      id_inst_d = fetch_ok ? mem[pc_q[AW+1:2]] : NOP;
      id_valid_d = fetch_ok;
      fault_d = fault_q | !fetch_ok;
    end
  end
  always_ff @(posedge CLK)
    if (RST) begin
      pc_q <= RESET_PC;
      id_pc_q <= '0;
      id_inst_q <= NOP;
      id_valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      id_pc_q <= id_pc_d;
      id_inst_q <= id_inst_d;
      id_valid_q <= id_valid_d;
      fault_q <= fault_d;
    end
  assign IF_ID_PC_OUT = id_pc_q;
  assign IF_ID_INST_OUT = id_inst_q;
  assign IF_ID_VALID = id_valid_q;
  assign IF_FAULT = fault_q;
endmodule
